pipe_stage_skid: RTL and testbench
==================================

Name: pipe_stage_skid

Overview:
- Parametrised elastic pipeline register for the 16-bit CPU datapath. It replaces plain enable-gated stage registers between pipeline stages.
- Carries a control bundle and a data payload between stages using a valid/ready handshake and a 2-entry skid buffer, so back-pressure never forms a combinational path upstream.
- Adds synchronous flush with bubble (NOP) insertion.
- Adds saturating stall and bubble performance counters.

Parameters:
- WIDTH, 16: data payload width (bits).
- CTRL_W, 8: control bundle width (branch/bypass/mem/jump/ALU op bits).
- CTRL_NOP, 0: control value presented when the stage holds a bubble; must encode a side-effect-free ADD.
- CNT_W, 16: width of each performance counter.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- flush  in  1  synchronous kill of all held and incoming entries
- clr_cnt  in  1  synchronous clear of both performance counters
- in_valid  in  1  upstream entry valid
- in_ready  out  1  stage can accept an entry this cycle
- in_ctrl  in  CTRL_W  upstream control bundle
- in_data  in  WIDTH  upstream payload
- out_valid  out  1  downstream entry valid
- out_ready  in  1  downstream accepts this cycle
- out_ctrl  out  CTRL_W  control to next stage; CTRL_NOP when out_valid=0
- out_data  out  WIDTH  payload to next stage
- occupancy  out  2  number of held entries, 0..2
- stall_cnt  out  CNT_W  cycles with out_valid=1 and out_ready=0
- bubble_cnt  out  CNT_W  cycles with out_valid=0 and out_ready=1

Behaviour:
- Storage: main register (drives outputs) plus one skid register.
- State machine EMPTY/ONE/FULL is encoded so that occupancy = 0/1/2.
- Fire definitions: in_fire = in_valid & in_ready; out_fire = out_valid & out_ready.
- Combinational outputs from state:
  - in_ready = (state != FULL). Decoded from state only, with no path from out_ready.
  - out_valid = (state != EMPTY).
  - out_ctrl = out_valid ? main_ctrl : CTRL_NOP.
- out_data holds main_data while valid and retains its last value while EMPTY.
- Reset (asynchronous, active-high), applied immediately on assertion:
  - state = EMPTY, hence in_ready=1, out_valid=0, occupancy=0.
  - main_ctrl = skid_ctrl = CTRL_NOP; main_data = skid_data = 0.
  - stall_cnt = bubble_cnt = 0.
- Transitions when flush=0:
  - EMPTY, in_fire: main<=in; go to ONE.
  - ONE, in_fire & out_fire: main<=in; stay in ONE.
  - ONE, out_fire only: go to EMPTY.
  - ONE, in_fire only: skid<=in; go to FULL.
  - FULL (in_ready=0), out_fire: main<=skid; go to ONE.
  - Any state, no fire: hold all state.
- Latency: 1 cycle from in_fire to out_valid when the stage is EMPTY.
- Throughput: 1 entry/cycle sustained while out_ready=1.
- Ordering: strictly FIFO; no entry is dropped or duplicated except by flush.
- Flush has the highest priority below reset:
  - Next state EMPTY; main_ctrl and skid_ctrl <= CTRL_NOP.
  - Any in_fire in the same cycle is discarded.
  - out_fire in the flush cycle still completes, since downstream observed it.
  - Data registers are left unchanged.
- Counters:
  - Each counter increments by 1 per qualifying cycle and saturates at 2^CNT_W-1, with no wrap.
  - clr_cnt=1 zeroes both counters next cycle and overrides a same-cycle increment.
  - Flush does not affect the counters.
  - A qualifying cycle is evaluated on pre-edge signal values.
- Boundary cases:
  - in_valid in FULL: ignored; upstream must hold in_ctrl/in_data until in_fire.
  - out_ready asserted while EMPTY: counted as a bubble; no state change.
  - Reset during FULL: both entries are lost with no further output.

Test Plan:
- Reset check: reset=1 then release, in_valid=0 → in_ready=1, out_valid=0, out_ctrl=CTRL_NOP, occupancy=0, both counters 0.
- Streaming: out_ready=1, inject 4 entries data 0x0001..0x0004 on consecutive cycles → each appears one cycle later, in order; occupancy stays 1; stall_cnt=0.
- Back-pressure: stream A=0x1111, B=0x2222, C=0x3333 with out_ready=0 from B's cycle → occupancy=2, in_ready=0, C held upstream; release out_ready → output order A,B,C with no loss; stall_cnt equals the number of blocked cycles.
- Flush in FULL: with occupancy=2, assert flush alongside in_valid with 0x4444 → next cycle out_valid=0, out_ctrl=CTRL_NOP, occupancy=0; 0x4444 never appears at the output.
- Counter saturation: with CNT_W=4, hold out_valid=1 and out_ready=0 for 20 cycles → stall_cnt=15; clr_cnt plus a qualifying cycle → 0.
- Bubble count: out_ready=1 with no input for 7 cycles → bubble_cnt=7, out_ctrl=CTRL_NOP throughout.

Source files
------------

// File: rtl/pipe_stage_skid.sv
// Elastic stage register with a 2-entry skid; 1-cycle latency from an empty stage, and in_ready
// is decoded from state alone so back-pressure never ripples upstream combinationally.
module pipe_stage_skid #(
    parameter int                WIDTH    = 16,
    parameter int                CTRL_W   = 8,
    parameter logic [CTRL_W-1:0] CTRL_NOP = '0,
    parameter int                CNT_W    = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              clr_cnt,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [WIDTH-1:0]  in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [WIDTH-1:0]  out_data,
    output logic [1:0]        occupancy,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  bubble_cnt
);

    typedef struct packed {
        logic [CTRL_W-1:0] ctrl;
        logic [WIDTH-1:0]  data;
    } entry_t;

    // Encoding doubles as the occupancy count.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    localparam entry_t            ENTRY_RST = {CTRL_NOP, {WIDTH{1'b0}}};
    localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

    state_t state, state_nxt;
    entry_t main_q, skid_q, in_ent;
    logic   in_fire, out_fire;
    logic   load_main_in, load_main_skid, load_skid;

    assign in_ent = {in_ctrl, in_data};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= EMPTY;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt      = state;
        load_main_in   = 1'b0;
        load_main_skid = 1'b0;
        load_skid      = 1'b0;
        in_ready       = (state != FULL);
        out_valid      = (state != EMPTY);
        in_fire        = in_valid & in_ready;
        out_fire       = out_valid & out_ready;
        if (flush) begin
            state_nxt = EMPTY;
        end else begin
            case (state)
                EMPTY: if (in_fire) begin
                    load_main_in = 1'b1;
                    state_nxt    = ONE;
                end
                ONE: if (in_fire && out_fire) begin
                    load_main_in = 1'b1;
                end else if (out_fire) begin
                    state_nxt = EMPTY;
                end else if (in_fire) begin
                    load_skid = 1'b1;
                    state_nxt = FULL;
                end
                FULL: if (out_fire) begin
                    load_main_skid = 1'b1;
                    state_nxt      = ONE;
                end
                default: state_nxt = EMPTY;
            endcase
        end
    end

    // Flush only scrubs control; payload is don't-care once invalid.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            main_q <= ENTRY_RST;
            skid_q <= ENTRY_RST;
        end else if (flush) begin
            main_q.ctrl <= CTRL_NOP;
            skid_q.ctrl <= CTRL_NOP;
        end else begin
            if (load_main_in)        main_q <= in_ent;
            else if (load_main_skid) main_q <= skid_q;
            if (load_skid)           skid_q <= in_ent;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cnt  <= '0;
            bubble_cnt <= '0;
        end else if (clr_cnt) begin
            stall_cnt  <= '0;
            bubble_cnt <= '0;
        end else begin
            if (out_valid && !out_ready && stall_cnt != CNT_MAX)
                stall_cnt <= stall_cnt + CNT_W'(1);
            if (!out_valid && out_ready && bubble_cnt != CNT_MAX)
                bubble_cnt <= bubble_cnt + CNT_W'(1);
        end
    end

    assign out_ctrl  = out_valid ? main_q.ctrl : CTRL_NOP;
    assign out_data  = main_q.data;
    assign occupancy = state;

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Bench for pipe_stage_skid: queue-based reference model checked every cycle, plus directed
// literal checks for reset, streaming, back-pressure, flush, counter saturation and bubbles.
module tb_pipe_stage_skid;

    localparam int                WIDTH   = 16;
    localparam int                CTRL_W  = 8;
    localparam int                CNT_W   = 4;
    localparam int                CNT_MAX = 15;
    localparam logic [CTRL_W-1:0] NOP     = 8'h00;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              flush = 1'b0;
    logic              clr_cnt = 1'b0;
    logic              in_valid = 1'b0;
    logic              out_ready = 1'b0;
    logic [CTRL_W-1:0] in_ctrl = '0;
    logic [WIDTH-1:0]  in_data = '0;
    logic              in_ready;
    logic              out_valid;
    logic [CTRL_W-1:0] out_ctrl;
    logic [WIDTH-1:0]  out_data;
    logic [1:0]        occupancy;
    logic [CNT_W-1:0]  stall_cnt;
    logic [CNT_W-1:0]  bubble_cnt;

    pipe_stage_skid #(
        .WIDTH(WIDTH), .CTRL_W(CTRL_W), .CTRL_NOP(NOP), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .reset(reset), .flush(flush), .clr_cnt(clr_cnt),
        .in_valid(in_valid), .in_ready(in_ready), .in_ctrl(in_ctrl), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_ctrl(out_ctrl), .out_data(out_data),
        .occupancy(occupancy), .stall_cnt(stall_cnt), .bubble_cnt(bubble_cnt)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endfunction

    // Reference model: the stage is a FIFO of at most two entries.
    typedef struct {
        logic [CTRL_W-1:0] c;
        logic [WIDTH-1:0]  d;
    } ent_t;

    ent_t             q[$];
    int               m_stall = 0;
    int               m_bubble = 0;
    logic [WIDTH-1:0] m_last = '0;

    initial begin
        forever begin
            @(posedge clk);
            if (reset) begin
                q.delete();
                m_stall  = 0;
                m_bubble = 0;
                m_last   = '0;
            end else begin
                bit   ov, ir, inf, outf;
                ent_t e;
                ov   = (q.size() > 0);
                ir   = (q.size() < 2);
                inf  = in_valid && ir;
                outf = ov && out_ready;
                if (clr_cnt) begin
                    m_stall  = 0;
                    m_bubble = 0;
                end else begin
                    if (ov && !out_ready && m_stall < CNT_MAX)   m_stall++;
                    if (!ov && out_ready && m_bubble < CNT_MAX)  m_bubble++;
                end
                if (outf) void'(q.pop_front());
                if (flush) q.delete();
                else if (inf) begin
                    e.c = in_ctrl;
                    e.d = in_data;
                    q.push_back(e);
                end
                if (q.size() > 0) m_last = q[0].d;
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (!reset) begin
                logic [CTRL_W-1:0] exp_ctrl;
                exp_ctrl = NOP;
                if (q.size() > 0) exp_ctrl = q[0].c;
                check("m_in_ready",  32'(in_ready),   32'(q.size() < 2));
                check("m_out_valid", 32'(out_valid),  32'(q.size() > 0));
                check("m_out_ctrl",  32'(out_ctrl),   32'(exp_ctrl));
                check("m_out_data",  32'(out_data),   32'(m_last));
                check("m_occupancy", 32'(occupancy),  32'(q.size()));
                check("m_stall",     32'(stall_cnt),  32'(m_stall));
                check("m_bubble",    32'(bubble_cnt), 32'(m_bubble));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [CTRL_W-1:0] c, input logic [WIDTH-1:0] d);
        in_valid = 1'b1;
        in_ctrl  = c;
        in_data  = d;
    endtask

    initial begin
        repeat (3) step();
        reset = 1'b0;
        step();
        check("rst_in_ready",  32'(in_ready),   32'd1);
        check("rst_out_valid", 32'(out_valid),  32'd0);
        check("rst_out_ctrl",  32'(out_ctrl),   32'(NOP));
        check("rst_occupancy", 32'(occupancy),  32'd0);
        check("rst_stall",     32'(stall_cnt),  32'd0);
        check("rst_bubble",    32'(bubble_cnt), 32'd0);

        // Streaming at full rate
        out_ready = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            push(8'(8'h10 + k), 16'(k));
            step();
            check("stream_data", 32'(out_data),  32'(k));
            check("stream_ctrl", 32'(out_ctrl),  32'(8'h10 + k));
            check("stream_occ",  32'(occupancy), 32'd1);
        end
        in_valid = 1'b0;
        step();
        check("stream_drain", 32'(occupancy), 32'd0);
        check("stream_stall", 32'(stall_cnt), 32'd0);

        // Back-pressure: A, B fill the stage, C waits upstream
        clr_cnt = 1'b1; step(); clr_cnt = 1'b0;
        push(8'h01, 16'h1111); step();
        push(8'h02, 16'h2222); out_ready = 1'b0; step();
        check("bp_occ_full", 32'(occupancy), 32'd2);
        check("bp_in_ready", 32'(in_ready),  32'd0);
        check("bp_head_a",   32'(out_data),  32'h1111);
        push(8'h03, 16'h3333); step(); step();
        out_ready = 1'b1; step();
        check("bp_order_b", 32'(out_data),  32'h2222);
        check("bp_occ_b",   32'(occupancy), 32'd1);
        step();
        check("bp_order_c", 32'(out_data), 32'h3333);
        in_valid = 1'b0; step();
        check("bp_occ_end", 32'(occupancy), 32'd0);
        check("bp_stall",   32'(stall_cnt), 32'd3);

        // Flush while FULL, with a competing input
        out_ready = 1'b0;
        push(8'h05, 16'h5555); step();
        push(8'h06, 16'h6666); step();
        check("fl_occ_full", 32'(occupancy), 32'd2);
        flush = 1'b1; push(8'h44, 16'h4444); step();
        flush = 1'b0; in_valid = 1'b0;
        check("fl_out_valid", 32'(out_valid), 32'd0);
        check("fl_out_ctrl",  32'(out_ctrl),  32'(NOP));
        check("fl_occ",       32'(occupancy), 32'd0);
        check("fl_data_kept", 32'(out_data),  32'h5555);
        out_ready = 1'b1;
        repeat (3) begin
            step();
            check("fl_no_ghost", 32'(out_valid), 32'd0);
        end

        // Flush in ONE discards an accepted input
        out_ready = 1'b0;
        push(8'h07, 16'h7777); step();
        flush = 1'b1; push(8'h08, 16'h8888); step();
        flush = 1'b0; in_valid = 1'b0;
        check("fl1_occ", 32'(occupancy), 32'd0);

        // Stall counter saturation
        clr_cnt = 1'b1; step(); clr_cnt = 1'b0;
        push(8'h09, 16'h9999); step(); in_valid = 1'b0;
        repeat (20) step();
        check("sat_stall", 32'(stall_cnt), 32'd15);
        clr_cnt = 1'b1; step(); clr_cnt = 1'b0;
        check("sat_clr", 32'(stall_cnt), 32'd0);
        step();
        check("sat_after_clr", 32'(stall_cnt), 32'd1);

        // Bubble counting
        out_ready = 1'b1; step();
        clr_cnt = 1'b1; step(); clr_cnt = 1'b0;
        repeat (7) begin
            step();
            check("bub_ctrl", 32'(out_ctrl), 32'(NOP));
        end
        check("bub_cnt", 32'(bubble_cnt), 32'd7);

        // Asynchronous reset while FULL
        out_ready = 1'b0;
        push(8'h0a, 16'haaaa); step();
        push(8'h0b, 16'hbbbb); step();
        in_valid = 1'b0;
        check("ar_occ_full", 32'(occupancy), 32'd2);
        #2 reset = 1'b1;
        #1;
        check("ar_occ",   32'(occupancy), 32'd0);
        check("ar_valid", 32'(out_valid), 32'd0);
        check("ar_ready", 32'(in_ready),  32'd1);
        @(posedge clk); #1;
        reset = 1'b0;
        out_ready = 1'b1;
        step();
        check("ar_no_output", 32'(out_valid), 32'd0);

        // Randomized traffic against the model
        repeat (3000) begin
            in_valid  = ($urandom_range(0, 9) < 7);
            out_ready = ($urandom_range(0, 9) < 6);
            flush     = ($urandom_range(0, 49) == 0);
            clr_cnt   = ($urandom_range(0, 99) == 0);
            in_ctrl   = 8'($urandom);
            in_data   = 16'($urandom);
            step();
        end
        in_valid = 1'b0;
        flush    = 1'b0;
        clr_cnt  = 1'b0;
        repeat (3) step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
